// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between the requesters and the
// round-robin arbiter that steers the shared 4:1 mux result path.
//  master : arbiter side (drives grant, mux selects and busy)
//  slave  : requester side (drives req and lock)
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       lock;
    logic [3:0] gnt;
    logic       op1;
    logic       op2;
    logic       busy;

    modport master (
        input  req,
        input  lock,
        output gnt,
        output op1,
        output op2,
        output busy
    );

    modport slave (
        output req,
        output lock,
        input  gnt,
        input  op1,
        input  op2,
        input  busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one mux1bit4to1 result path
// among 4 requesters. Grants one requester at a time, drives the mux selects
// {op2,op1} with the owner index and bounds tenure with a hold timer so that
// a waiting requester is never starved. All outputs are registered.
//
// Optional feature macro: MUX_ARB_LOCK_EN
//  defined   : lock=1 from the owner suppresses preemption (tenure unbounded).
//  undefined : lock is accepted but ignored; MAX_HOLD is always enforced.
//
// MAX_HOLD must be >= 1 and CNT_W must satisfy 2**CNT_W > MAX_HOLD.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mux4_rr_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_op;
    logic             r_busy;
    logic [CNT_W-1:0] r_hold;
    logic [1:0]       r_last;

    logic [3:0]       w_mask;
    logic [1:0]       w_win;
    logic             w_found;
    logic             w_owner_req;
    logic             w_lock_hold;
    logic             w_preempt;

    // Candidates exclude the current owner; in IDLE r_gnt is zero, and on
    // release the owner's req is already low, so one scan serves all cases.
    assign w_mask      = bus.req & ~r_gnt;
    assign w_owner_req = |(bus.req & r_gnt);

`ifdef MUX_ARB_LOCK_EN
    assign w_lock_hold = bus.lock;
`else
    // lock is part of the port set but has no effect in this build.
    assign w_lock_hold = 1'b0;
`endif

    // Counter keeps counting under lock, so a late lock drop preempts at once.
    assign w_preempt = w_found && (r_hold >= HoldLast) && !w_lock_hold;

    // Round-robin scan: first candidate from last+1 upward, wrapping mod 4.
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_mask[r_last + 2'(k)]) begin
                w_win   = r_last + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    // Arbiter FSM with registered grant, selects, busy and hold counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_gnt   <= 4'b0000;
            r_op    <= 2'd0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_last  <= 2'd3;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state <= StGrant;
                        r_gnt   <= 4'b0001 << w_win;
                        r_op    <= w_win;
                        r_busy  <= 1'b1;
                        r_last  <= w_win;
                        r_hold  <= '0;
                    end
                end
                StGrant: begin
                    if (!w_owner_req || w_preempt) begin
                        if (w_found) begin
                            // Direct handoff, no idle bubble.
                            r_gnt  <= 4'b0001 << w_win;
                            r_op   <= w_win;
                            r_last <= w_win;
                            r_hold <= '0;
                        end else begin
                            // op1/op2 deliberately keep their last value.
                            r_state <= StIdle;
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                            r_hold  <= '0;
                        end
                    end else if (r_hold != HoldMax) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.op1  = r_op[0];
    assign bus.op2  = r_op[1];
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter. The stimulus
// process runs a behavioural arbiter model (owner index, tenure length,
// rotating pointer) and queues the expected registered outputs for each
// clock edge; a separate monitor pops and compares after every edge.
module tb_mux4_rr_arbiter;

    localparam int MaxHold = 8;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

    // Model state: owner index (-1 = none), cycles owned so far, pointer.
    int m_owner = -1;
    int m_tenure = 0;
    int m_last = 3;
    int m_op = 0;

    function automatic int pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic give(input int w);
        m_owner  = w;
        m_last   = w;
        m_op     = w;
        m_tenure = 1;
    endtask

    // Outcome of one clock edge given the inputs held during that cycle.
    task automatic model_edge(input logic [3:0] r, input logic l, input logic rs);
        logic [3:0] others;
        if (rs) begin
            m_owner  = -1;
            m_tenure = 0;
            m_last   = 3;
            m_op     = 0;
        end else if (m_owner < 0) begin
            if (r != 4'b0) give(pick(r, m_last));
        end else if (!r[m_owner]) begin
            if (r != 4'b0) give(pick(r, m_last));
            else m_owner = -1;
        end else begin
            others = r & ~(4'b0001 << m_owner);
            if (others != 4'b0 && m_tenure >= MaxHold && !(LockEn && l))
                give(pick(others, m_last));
            else
                m_tenure++;
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        logic [1:0] op;
        g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        op = 2'(m_op);
        return {g, op[1], op[0], (m_owner >= 0)};
    endfunction

    task automatic step(input logic [3:0] r, input logic l, input logic rs);
        bus.req  = r;
        bus.lock = l;
        rst      = rs;
        model_edge(r, l, rs);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic repeat_step(input int n, input logic [3:0] r, input logic l);
        for (int i = 0; i < n; i++) step(r, l, 1'b0);
    endtask

    // Monitor: one expected entry per edge, sampled 3 time units after it.
    initial begin
        logic [6:0] e;
        logic [6:0] act;
        logic [3:0] enc;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.gnt, bus.op2, bus.op1, bus.busy};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got gnt=%b op2=%b op1=%b busy=%b want gnt=%b op2=%b op1=%b busy=%b",
                             $time, act[6:3], act[2], act[1], act[0], e[6:3], e[2], e[1], e[0]);
                end
                enc = 4'b0001 << {bus.op2, bus.op1};
                total++;
                if ($countones(bus.gnt) > 1 || bus.busy !== (|bus.gnt) ||
                    (bus.busy && bus.gnt !== enc)) begin
                    bad++;
                    $display("FAIL invariant t=%0t got gnt=%b op={%b,%b} busy=%b want onehot0 gnt matching ops",
                             $time, bus.gnt, bus.op2, bus.op1, bus.busy);
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        int stay[4];
        bus.req  = 4'b0;
        bus.lock = 1'b0;
        rst      = 1'b1;

        // Reset with all requests pending.
        step(4'hF, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b1);
        // Single requester from idle, then release.
        repeat_step(2, 4'b0000, 1'b0);
        repeat_step(3, 4'b0100, 1'b0);
        repeat_step(2, 4'b0000, 1'b0);
        // Full rotation with everyone requesting.
        repeat_step(42, 4'hF, 1'b0);
        repeat_step(2, 4'b0000, 1'b0);
        // Release handoff from owner 1 to requester 2.
        step(4'h0, 1'b0, 1'b1);
        repeat_step(2, 4'b0010, 1'b0);
        repeat_step(3, 4'b0110, 1'b0);
        repeat_step(3, 4'b0100, 1'b0);
        repeat_step(2, 4'b0000, 1'b0);
        // Lone owner saturates, then a late requester takes over at once.
        step(4'h0, 1'b0, 1'b1);
        repeat_step(20, 4'b0001, 1'b0);
        repeat_step(3, 4'b1001, 1'b0);
        repeat_step(2, 4'b0000, 1'b0);
        // Lock held by owner 0 with requester 1 waiting, then lock drops.
        step(4'h0, 1'b0, 1'b1);
        repeat_step(30, 4'b0011, 1'b1);
        repeat_step(3, 4'b0011, 1'b0);
        // Reset in the middle of a tenure.
        repeat_step(2, 4'b0110, 1'b0);
        step(4'b0110, 1'b0, 1'b1);
        repeat_step(3, 4'b0110, 1'b0);
        repeat_step(2, 4'b0000, 1'b0);

        // Random traffic: a request stays up until its owner has been served
        // for a random number of cycles (possibly across preemptions).
        rq = 4'b0;
        for (int i = 0; i < 4; i++) stay[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i] && m_owner == i) begin
                    stay[i]--;
                    if (stay[i] <= 0) rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(0, 5) == 0) begin
                    rq[i]   = 1'b1;
                    stay[i] = int'($urandom_range(1, 14));
                end
            end
            step(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 249) == 0));
        end
        step(4'b0000, 1'b0, 1'b0);

        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
